// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: board geometry defaults, scan FSM encoding and the
// cell-index mapping used by both the generation engine and the scan transmitter.
package gol_pkg;

    localparam int unsigned GolRows = 16;
    localparam int unsigned GolCols = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2,
        StHold  = 2'd3
    } scan_state_e;

    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/board_row_shifter.sv
// Serialises one board row MSB-first onto a 74HC595 chain: ser_clk low CLK_DIV cycles with
// ser_data settled, then high CLK_DIV cycles. done is high in the final cycle of the row.
module board_row_shifter #(
    parameter int unsigned COLS    = 16,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [COLS-1:0] row_in,
    output logic            ser_data,
    output logic            ser_clk,
    output logic            done
);

    localparam int unsigned BW = $clog2(COLS);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BitLast = BW'(COLS - 1);
    localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

    logic            busy_q, busy_d;
    logic            ser_clk_q, ser_clk_d;
    logic            ser_data_q, ser_data_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [COLS-1:0] sreg_q, sreg_d;

    always_comb begin
        busy_d     = busy_q;
        ser_clk_d  = ser_clk_q;
        ser_data_d = ser_data_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sreg_d     = sreg_q;
        done       = 1'b0;
        if (start) begin
            busy_d     = 1'b1;
            ser_clk_d  = 1'b0;
            div_d      = '0;
            bit_d      = '0;
            sreg_d     = row_in;
            ser_data_d = row_in[COLS-1];
        end else if (busy_q) begin
            if (div_q == DivLast) begin
                div_d = '0;
                if (!ser_clk_q) begin
                    ser_clk_d = 1'b1;
                end else begin
                    // Falling edge: present the next bit so it is stable for the whole low phase.
                    ser_clk_d = 1'b0;
                    if (bit_q == BitLast) begin
                        done       = 1'b1;
                        busy_d     = 1'b0;
                        ser_data_d = 1'b0;
                    end else begin
                        bit_d      = bit_q + BW'(1);
                        sreg_d     = {sreg_q[COLS-2:0], 1'b0};
                        ser_data_d = sreg_q[COLS-2];
                    end
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            ser_clk_q  <= 1'b0;
            ser_data_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            sreg_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            ser_clk_q  <= ser_clk_d;
            ser_data_q <= ser_data_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sreg_q     <= sreg_d;
        end
    end

    assign ser_data = ser_data_q;
    assign ser_clk  = ser_clk_q;

endmodule

// File: rtl/board_scan_tx.sv
// Double-buffered board scanner: accepts board snapshots and scans them row by row onto an LED
// matrix. Optional BOARD_SCAN_DIM_EN adds a dim[3:0] input for per-row brightness control.
module board_scan_tx
    import gol_pkg::*;
#(
    parameter int unsigned ROWS     = GolRows,
    parameter int unsigned COLS     = GolCols,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned ROW_HOLD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic                 load_valid,
`ifdef BOARD_SCAN_DIM_EN
    input  logic [3:0]           dim,
`endif
    output logic                 load_ready,
    output logic                 ser_data,
    output logic                 ser_clk,
    output logic                 ser_latch,
    output logic [ROWS-1:0]      row_sel,
    output logic                 frame_done
);

    localparam int unsigned NCells = ROWS * COLS;
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned HW     = $clog2(ROW_HOLD) + 1;
    localparam logic [RW-1:0] RowLast  = RW'(ROWS - 1);
    localparam logic [HW-1:0] HoldLast = HW'(ROW_HOLD - 1);

    scan_state_e       state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NCells-1:0] active_q, active_d;
    logic [NCells-1:0] pending_q, pending_d;
    logic              pending_full_q, pending_full_d;
    logic              shift_start;
    logic              shift_done;
    logic [COLS-1:0]   shift_row;
    logic              drive_en;

`ifdef BOARD_SCAN_DIM_EN
    logic [3:0]  dim_q, dim_d;
    logic [31:0] dim_lim;

    assign dim_lim = ((32'(dim_q) + 32'd1) * ROW_HOLD) / 32'd16;
`endif

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        hold_d         = hold_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        shift_start    = 1'b0;
        frame_done     = 1'b0;
`ifdef BOARD_SCAN_DIM_EN
        dim_d          = dim_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pending_full_q) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                    row_d          = '0;
                    shift_start    = 1'b1;
                    state_d        = StShift;
                end
            end
            StShift: begin
                if (shift_done) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                hold_d  = '0;
                state_d = StHold;
`ifdef BOARD_SCAN_DIM_EN
                dim_d   = dim;
`endif
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    hold_d      = '0;
                    shift_start = 1'b1;
                    state_d     = StShift;
                    if (row_q == RowLast) begin
                        // Frame boundary: swap in a waiting board, otherwise repeat the active one.
                        frame_done = 1'b1;
                        row_d      = '0;
                        if (pending_full_q) begin
                            active_d       = pending_q;
                            pending_full_d = 1'b0;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // A take above needs pending_full_q=1 and an accept needs it 0, so they never collide.
        if (load_valid && !pending_full_q) begin
            pending_d      = board_in;
            pending_full_d = 1'b1;
        end
    end

    // Row handed to the shifter is taken from next-state buffers so it starts on the same edge.
    always_comb begin
        shift_row = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            shift_row[c] = active_d[cell_idx(32'(row_d), c, COLS)];
        end
    end

    always_comb begin
        row_sel  = '0;
        drive_en = 1'b1;
`ifdef BOARD_SCAN_DIM_EN
        drive_en = (32'(hold_q) < dim_lim);
`endif
        if ((state_q == StHold) && drive_en) begin
            row_sel[row_q] = 1'b1;
        end
    end

    assign load_ready = !pending_full_q;
    assign ser_latch  = (state_q == StLatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            row_q          <= '0;
            hold_q         <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
`ifdef BOARD_SCAN_DIM_EN
            dim_q          <= 4'hF;
`endif
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            hold_q         <= hold_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
`ifdef BOARD_SCAN_DIM_EN
            dim_q          <= dim_d;
`endif
        end
    end

    board_row_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (shift_start),
        .row_in   (shift_row),
        .ser_data (ser_data),
        .ser_clk  (ser_clk),
        .done     (shift_done)
    );

endmodule
